// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, ALU op codes
// and the set of ops whose carry output is architecturally visible.
package alu_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_REG_NUM = 8;
  localparam int DEF_ADDR_W  = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1011;
  localparam logic [3:0] OP_EQ  = 4'b1100;
  localparam logic [3:0] OP_NOP = 4'b1101;

  // Bit n set means op code n updates flag_carry (add and sub only).
  localparam logic [15:0] CARRY_OPS = 16'b0000_0000_0000_0011;

  function automatic logic op_sets_carry(input logic [3:0] op);
    return CARRY_OPS[op];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue stage: REG_NUM x DATA_W, asynchronous
// reset, two combinational operand read ports, one debug read port and a
// single write port shared by writeback and host load (load has priority).
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [REG_NUM];

  // Single write port: a host load to the same entry overrides writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (ld_en && (ld_addr == ADDR_W'(i))) begin
          mem[i] <= ld_data;
        end else if (wb_en && (wb_addr == ADDR_W'(i))) begin
          mem[i] <= wb_data;
        end
      end
    end
  end

  // Combinational reads; no bypass of same-edge writes.
  always_comb begin
    rs_data  = mem[rs_addr];
    rt_data  = mem[rt_addr];
    dbg_data = mem[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage feeding an external combinational 8-bit ALU.
// Instructions are accepted over valid/ready, operands are registered into
// the ALU, and the ALU result is written back one cycle later.
// Build option ALU_FWD_EN: when defined, an EX-to-issue bypass removes the
// read-after-write stall; when undefined, a dependent instruction waits one
// cycle with in_ready low.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready depends only on ld_en and (without the
// bypass) on a RAW hazard against the instruction in EX; it never depends on
// the ALU side, so the stage always drains. in_valid may be raised or
// dropped freely; the offered fields are only meaningful while it is high.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_NUM = DEF_REG_NUM,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_carry,
  output logic              flag_zero,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] src_x;
  logic [DATA_W-1:0] src_y;
  logic              stall;
  logic              accept;

  alu_regfile #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_en    (ex_valid),
    .wb_addr  (ex_rd),
    .wb_data  (alu_out),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rs_addr  (in_rs),
    .rs_data  (rs_data),
    .rt_addr  (in_rt),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Operand selection, hazard handling and the ready decision.
  always_comb begin
    src_x = rs_data;
    src_y = in_imm_en ? in_imm : rt_data;
    stall = 1'b0;
`ifdef ALU_FWD_EN
    if (ex_valid && (in_rs == ex_rd)) src_x = alu_out;
    if (ex_valid && !in_imm_en && (in_rt == ex_rd)) src_y = alu_out;
`else
    stall = in_valid && ex_valid &&
            ((in_rs == ex_rd) || (!in_imm_en && (in_rt == ex_rd)));
`endif
    in_ready = !ld_en && !stall;
    accept   = in_valid && in_ready;
  end

  // Issue register: drive the ALU with the accepted instruction, else a nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= OP_NOP;
      alu_x    <= '0;
      alu_y    <= '0;
      ex_rd    <= '0;
      ex_valid <= 1'b0;
    end else if (accept) begin
      alu_ctrl <= in_op;
      alu_x    <= src_x;
      alu_y    <= src_y;
      ex_rd    <= in_rd;
      ex_valid <= 1'b1;
    end else begin
      alu_ctrl <= OP_NOP;
      ex_valid <= 1'b0;
    end
  end

  // Writeback report and flags, captured from the ALU at the end of EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else begin
      wb_valid <= ex_valid;
      if (ex_valid) begin
        wb_rd     <= ex_rd;
        wb_data   <= alu_out;
        flag_zero <= (alu_out == '0);
        if (op_sets_carry(alu_ctrl)) flag_carry <= alu_carry;
      end
    end
  end

endmodule
